// File: rtl/refresh_issuer.sv
// Refresh issuer: accrues tREFI obligations, asks the tracker whether each
// slot needs a real REF, and either retires it silently or issues it.
module refresh_issuer #(
   parameter int TREFI    = 3900,
   parameter int TRFC     = 350,
   parameter int MAX_PEND = 8,
   parameter int CNT_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ref_en,
   output logic                          to_refresh,
   input  logic                          dref,
   output logic                          ref_req,
   input  logic                          ref_gnt,
   output logic                          ref_busy,
   output logic                          ref_urgent,
   output logic [$clog2(MAX_PEND):0]     pending,
   output logic [CNT_W-1:0]              skip_cnt,
   output logic [CNT_W-1:0]              issue_cnt,
   output logic                          err_ovf
);

   localparam int TW       = $clog2(TREFI);
   localparam int PW       = $clog2(MAX_PEND) + 1;
   localparam int RW       = (TRFC > 2) ? $clog2(TRFC) : 1;
   localparam int RFC_INIT = (TRFC > 1) ? TRFC - 2 : 0;

   typedef enum logic [2:0] {
      IDLE,
      QUERY,
      DECIDE,
      REQ,
      WAIT_RFC
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] timer;
   logic [RW-1:0] rfc_cnt;
   logic          tick;
   logic          skip;
   logic          grant;
   logic          retire;
   logic          pend_full;
   logic          pend_zero;

   assign tick       = ref_en && (timer == TW'(TREFI - 1));
   assign skip       = (state == DECIDE) && dref;
   assign grant      = (state == REQ) && ref_gnt;
   assign retire     = skip || grant;
   assign pend_full  = (pending == PW'(MAX_PEND));
   assign pend_zero  = (pending == '0);
   assign ref_urgent = (pending >= PW'(MAX_PEND - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (!ref_en || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // A tick and a retire in the same cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (tick && pend_full) begin
            err_ovf <= 1'b1;
         end
         if (tick && !retire && !pend_full) begin
            pending <= pending + 1'b1;
         end else if (retire && !tick && !pend_zero) begin
            pending <= pending - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_cnt  <= '0;
         issue_cnt <= '0;
      end else begin
         if (skip) begin
            skip_cnt <= skip_cnt + 1'b1;
         end
         if (grant) begin
            issue_cnt <= issue_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfc_cnt <= '0;
      end else if (grant) begin
         rfc_cnt <= RW'(RFC_INIT);
      end else if (state == WAIT_RFC && rfc_cnt != '0) begin
         rfc_cnt <= rfc_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // The grant cycle itself counts as the first busy cycle
   always_comb begin
      state_n    = state;
      to_refresh = 1'b0;
      ref_req    = 1'b0;
      ref_busy   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!pend_zero) begin
               state_n = QUERY;
            end
         end
         QUERY: begin
            to_refresh = 1'b1;
            state_n    = DECIDE;
         end
         DECIDE: begin
            state_n = dref ? IDLE : REQ;
         end
         REQ: begin
            ref_req = 1'b1;
            if (ref_gnt) begin
               ref_busy = 1'b1;
               state_n  = (TRFC > 1) ? WAIT_RFC : IDLE;
            end
         end
         WAIT_RFC: begin
            ref_busy = 1'b1;
            if (rfc_cnt == '0) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_refresh_issuer.sv
// Directed bench for refresh_issuer with TREFI=20, TRFC=5, MAX_PEND=4.
// Cycle N is the Nth clock period after reset release, sampled at negedge.
module tb_refresh_issuer;

   localparam int TREFI    = 20;
   localparam int TRFC     = 5;
   localparam int MAX_PEND = 4;
   localparam int CNT_W    = 16;

   logic                      clk;
   logic                      rst_n;
   logic                      ref_en;
   logic                      to_refresh;
   logic                      dref;
   logic                      ref_req;
   logic                      ref_gnt;
   logic                      ref_busy;
   logic                      ref_urgent;
   logic [$clog2(MAX_PEND):0] pending;
   logic [CNT_W-1:0]          skip_cnt;
   logic [CNT_W-1:0]          issue_cnt;
   logic                      err_ovf;

   logic gnt_man;
   logic tie;
   int   errors;
   int   checks;
   int   cyc;

   assign ref_gnt = tie ? ref_req : gnt_man;

   refresh_issuer #(
      .TREFI   (TREFI),
      .TRFC    (TRFC),
      .MAX_PEND(MAX_PEND),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ref_en    (ref_en),
      .to_refresh(to_refresh),
      .dref      (dref),
      .ref_req   (ref_req),
      .ref_gnt   (ref_gnt),
      .ref_busy  (ref_busy),
      .ref_urgent(ref_urgent),
      .pending   (pending),
      .skip_cnt  (skip_cnt),
      .issue_cnt (issue_cnt),
      .err_ovf   (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic adv_to(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset(input logic en, input logic d,
                           input logic t);
      rst_n   = 1'b0;
      ref_en  = en;
      dref    = d;
      tie     = t;
      gnt_man = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      int nb;
      int first_busy;
      logic any_req;
      logic any_q;
      errors  = 0;
      checks  = 0;
      cyc     = 0;
      gnt_man = 1'b0;
      tie     = 1'b0;
      dref    = 1'b0;
      ref_en  = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("rst_pending", 32'(pending), 0);
      chk("rst_req", 32'(ref_req), 0);
      chk("rst_busy", 32'(ref_busy), 0);
      chk("rst_toref", 32'(to_refresh), 0);
      chk("rst_urgent", 32'(ref_urgent), 0);
      chk("rst_ovf", 32'(err_ovf), 0);
      chk("rst_cnts", 32'({skip_cnt, issue_cnt}), 0);

      // 1: first tick, query, immediate grant, busy window
      do_reset(1'b1, 1'b0, 1'b1);
      adv_to(20);
      chk("t1_pend20", 32'(pending), 1);
      chk("t1_toref20", 32'(to_refresh), 0);
      adv_to(21);
      chk("t1_toref21", 32'(to_refresh), 1);
      adv_to(22);
      chk("t1_req22", 32'(ref_req), 0);
      nb         = 0;
      first_busy = -1;
      for (int i = 22; i <= 30; i++) begin
         adv_to(i);
         if (ref_busy) begin
            nb++;
            if (first_busy < 0) first_busy = i;
         end
         if (i == 23) chk("t1_req23", 32'(ref_req), 1);
      end
      chk("t1_busy_len", 32'(nb), 5);
      chk("t1_busy_first", 32'(first_busy), 23);
      chk("t1_issue", 32'(issue_cnt), 1);
      chk("t1_pend_end", 32'(pending), 0);

      // 2: tracker always answers dummy
      do_reset(1'b1, 1'b1, 1'b1);
      any_req = 1'b0;
      for (int i = 1; i <= 103; i++) begin
         adv_to(i);
         any_req = any_req | ref_req;
         if (i == 100) chk("t2_skip100", 32'(skip_cnt), 4);
      end
      chk("t2_noreq", 32'(any_req), 0);
      chk("t2_skip103", 32'(skip_cnt), 5);
      chk("t2_issue", 32'(issue_cnt), 0);

      // 3: grant withheld, saturation and overflow, then drain
      do_reset(1'b1, 1'b0, 1'b0);
      adv_to(59);
      chk("t3_pend59", 32'(pending), 2);
      chk("t3_urg59", 32'(ref_urgent), 0);
      adv_to(60);
      chk("t3_pend60", 32'(pending), 3);
      chk("t3_urg60", 32'(ref_urgent), 1);
      adv_to(80);
      chk("t3_pend80", 32'(pending), 4);
      adv_to(99);
      chk("t3_ovf99", 32'(err_ovf), 0);
      adv_to(100);
      chk("t3_ovf100", 32'(err_ovf), 1);
      chk("t3_req100", 32'(ref_req), 1);
      chk("t3_pend100", 32'(pending), 4);
      ref_en = 1'b0;
      tie    = 1'b1;
      #1;
      nb = 0;
      for (int i = 100; i <= 130; i++) begin
         adv_to(i);
         nb += int'(ref_busy);
         if (i == 101) chk("t3_pend101", 32'(pending), 3);
         if (i == 106) chk("t3_toref106", 32'(to_refresh), 1);
      end
      chk("t3_busy_tot", 32'(nb), 20);
      chk("t3_issue", 32'(issue_cnt), 4);
      chk("t3_pend_end", 32'(pending), 0);
      chk("t3_ovf_sticky", 32'(err_ovf), 1);

      // 4: tick coincides with grant retire
      do_reset(1'b1, 1'b0, 1'b0);
      adv_to(39);
      chk("t4_req39", 32'(ref_req), 1);
      gnt_man = 1'b1;
      adv_to(40);
      gnt_man = 1'b0;
      tie     = 1'b1;
      chk("t4_pend40", 32'(pending), 1);
      chk("t4_issue40", 32'(issue_cnt), 1);
      adv_to(45);
      chk("t4_toref45", 32'(to_refresh), 1);
      adv_to(48);
      chk("t4_pend48", 32'(pending), 0);
      chk("t4_issue48", 32'(issue_cnt), 2);

      // 5: asynchronous reset while in WAIT_RFC with an obligation pending
      do_reset(1'b1, 1'b0, 1'b0);
      adv_to(39);
      gnt_man = 1'b1;
      adv_to(40);
      gnt_man = 1'b0;
      adv_to(41);
      chk("t5_busy41", 32'(ref_busy), 1);
      chk("t5_pend41", 32'(pending), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(ref_busy), 0);
      chk("t5_rst_req", 32'(ref_req), 0);
      chk("t5_rst_pend", 32'(pending), 0);
      do_reset(1'b1, 1'b0, 1'b1);
      any_q = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         adv_to(i);
         any_q = any_q | to_refresh;
      end
      chk("t5_noq_early", 32'(any_q), 0);
      adv_to(21);
      chk("t5_toref21", 32'(to_refresh), 1);

      // 6: ref_en low with two obligations: drain, then no accrual
      do_reset(1'b1, 1'b0, 1'b0);
      adv_to(40);
      chk("t6_pend40", 32'(pending), 2);
      ref_en = 1'b0;
      tie    = 1'b1;
      adv_to(41);
      dref = 1'b1;
      chk("t6_pend41", 32'(pending), 1);
      adv_to(48);
      chk("t6_pend48", 32'(pending), 0);
      any_q = 1'b0;
      for (int i = 49; i <= 100; i++) begin
         adv_to(i);
         any_q = any_q | to_refresh;
      end
      chk("t6_noq", 32'(any_q), 0);
      chk("t6_skip", 32'(skip_cnt), 1);
      chk("t6_issue", 32'(issue_cnt), 1);
      ref_en = 1'b1;
      adv_to(119);
      chk("t6_pend119", 32'(pending), 0);
      adv_to(120);
      chk("t6_pend120", 32'(pending), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
